// File: rtl/cmac_feeder_pkg.sv
// Shared definitions for the CMAC message feeder: FSM states, block geometry,
// length/padding constants and the byte-count-to-mask helper.
package cmac_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEY_WAIT,
        COLLECT,
        BLK_WAIT,
        LAST_WAIT
    } state_t;

    localparam int        WORDS_PER_BLK = 4;
    localparam logic [7:0] LEN_FULL     = 8'd128;
    localparam logic [7:0] PAD_MARK     = 8'h80;

    // Mask keeping the first nbytes bytes of a block (byte 0 in [127:120]).
    function automatic logic [127:0] byte_mask(input logic [4:0] nbytes);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(nbytes)) begin
                m[127-8*i -: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/cmac_blk_pad.sv
// Final-block formatter: keeps the first nbytes bytes of the assembled block,
// zeroes the rest and reports the length in bits.
// Build option CMAC_FEEDER_PAD_EN: when defined, the byte right after the
// message data gets the 8'h80 marker (10* padding); otherwise the tail is
// simply zero-filled and padding is left to the core.
module cmac_blk_pad
    import cmac_feeder_pkg::*;
(
    input  logic [127:0] blk,
    input  logic [4:0]   nbytes,
    output logic [127:0] padded,
    output logic [7:0]   len
);

    logic [127:0] kept;

    assign kept = blk & byte_mask(nbytes);

    // Per-byte selection between kept data and the padding marker.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
`ifdef CMAC_FEEDER_PAD_EN
            assign padded[127-8*gi -: 8] = (nbytes == 5'(gi)) ? PAD_MARK : kept[127-8*gi -: 8];
`else
            assign padded[127-8*gi -: 8] = kept[127-8*gi -: 8];
`endif
        end
    endgenerate

    // A full block reports 128; shorter blocks report 8 bits per byte.
    assign len = (nbytes >= 5'd16) ? LEN_FULL : {nbytes, 3'b000};

endmodule

// File: rtl/cmac_msg_feeder.sv
// CMAC message feeder: turns a 32-bit word stream plus key into the core's
// key/block load sequence with one-block lookahead, so the final block is
// known before it is issued, and captures the final core output as the tag.
// Build option CMAC_FEEDER_PAD_EN selects feeder-side 10* padding (see cmac_blk_pad).
module cmac_msg_feeder
    import cmac_feeder_pkg::*;
(
    input  logic         CLK,
    input  logic         Rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_last,
    input  logic [2:0]   s_bytes,
    output logic [127:0] cm_KEY,
    output logic [127:0] cm_TextIn,
    output logic         cm_ld_Key,
    output logic         cm_ld_Block,
    output logic         cm_Last_Block,
    output logic [7:0]   cm_Last_Block_Len,
    input  logic         cm_Done,
    input  logic [127:0] cm_TextOut,
    output logic [127:0] tag,
    output logic         tag_valid,
    output logic         busy
);

    state_t       state_reg;
    logic [31:0]  asm_reg [WORDS_PER_BLK];
    logic [2:0]   wcnt_reg;
    logic [127:0] pend_reg;
    logic         pend_v_reg;
    logic         fin_reg;
    logic [4:0]   fin_bytes_reg;

    logic         accept;
    logic         pend_free;
    logic [2:0]   bytes_clamped;
    logic [4:0]   last_bytes;
    logic [127:0] asm_blk;
    logic [127:0] pad_blk;
    logic [7:0]   pad_len;

    // Accept only while collecting, before the last word, and while asm has room.
    assign s_ready = ((state_reg == COLLECT) || (state_reg == BLK_WAIT)) &&
                     !fin_reg && (wcnt_reg != 3'd4);
    assign accept  = s_valid && s_ready;

    // pend can take a new block if empty or if its in-flight copy completes now.
    assign pend_free = !pend_v_reg || ((state_reg == BLK_WAIT) && cm_Done);

    assign bytes_clamped = (s_bytes > 3'd4) ? 3'd4 : s_bytes;
    assign last_bytes    = {1'b0, wcnt_reg[1:0], 2'b00} + {2'b00, bytes_clamped};
    assign asm_blk       = {asm_reg[0], asm_reg[1], asm_reg[2], asm_reg[3]};

    cmac_blk_pad u_pad (
        .blk    (asm_blk),
        .nbytes (fin_bytes_reg),
        .padded (pad_blk),
        .len    (pad_len)
    );

    // Sequencing FSM with registered core-side outputs, followed by word storage.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_reg         <= IDLE;
            for (int i = 0; i < WORDS_PER_BLK; i++) asm_reg[i] <= '0;
            wcnt_reg          <= '0;
            pend_reg          <= '0;
            pend_v_reg        <= 1'b0;
            fin_reg           <= 1'b0;
            fin_bytes_reg     <= '0;
            cm_KEY            <= '0;
            cm_TextIn         <= '0;
            cm_ld_Key         <= 1'b0;
            cm_ld_Block       <= 1'b0;
            cm_Last_Block     <= 1'b0;
            cm_Last_Block_Len <= '0;
            tag               <= '0;
            tag_valid         <= 1'b0;
            busy              <= 1'b0;
        end else begin
            cm_ld_Key   <= 1'b0;
            cm_ld_Block <= 1'b0;
            tag_valid   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (key_load) begin
                        cm_KEY     <= key_in;
                        cm_ld_Key  <= 1'b1;
                        wcnt_reg   <= '0;
                        pend_v_reg <= 1'b0;
                        fin_reg    <= 1'b0;
                        busy       <= 1'b1;
                        state_reg  <= KEY_WAIT;
                    end
                end
                KEY_WAIT: begin
                    if (cm_Done) state_reg <= COLLECT;
                end
                COLLECT: begin
                    if (pend_v_reg && (wcnt_reg != 3'd0)) begin
                        // Something follows pend, so pend is definitely not last.
                        cm_TextIn         <= pend_reg;
                        cm_Last_Block     <= 1'b0;
                        cm_Last_Block_Len <= LEN_FULL;
                        cm_ld_Block       <= 1'b1;
                        state_reg         <= BLK_WAIT;
                    end else if (fin_reg && !pend_v_reg) begin
                        cm_TextIn         <= pad_blk;
                        cm_Last_Block     <= 1'b1;
                        cm_Last_Block_Len <= pad_len;
                        cm_ld_Block       <= 1'b1;
                        state_reg         <= LAST_WAIT;
                    end else if ((wcnt_reg == 3'd4) && !pend_v_reg) begin
                        // asm filled while pend was in flight; shift it down now.
                        pend_reg   <= asm_blk;
                        pend_v_reg <= 1'b1;
                        wcnt_reg   <= '0;
                    end
                end
                BLK_WAIT: begin
                    if (cm_Done) begin
                        pend_v_reg <= 1'b0;
                        state_reg  <= COLLECT;
                    end
                end
                LAST_WAIT: begin
                    if (cm_Done) begin
                        tag       <= cm_TextOut;
                        tag_valid <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Word storage; a completed non-last block moves straight to pend if free.
            if (accept) begin
                asm_reg[wcnt_reg[1:0]] <= s_data;
                if (s_last) begin
                    fin_reg       <= 1'b1;
                    fin_bytes_reg <= last_bytes;
                    wcnt_reg      <= 3'(wcnt_reg + 3'd1);
                end else if ((wcnt_reg == 3'd3) && pend_free) begin
                    pend_reg   <= {asm_reg[0], asm_reg[1], asm_reg[2], s_data};
                    pend_v_reg <= 1'b1;
                    wcnt_reg   <= '0;
                end else begin
                    wcnt_reg <= 3'(wcnt_reg + 3'd1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cmac_msg_feeder.sv
// Scoreboard bench for cmac_msg_feeder with a behavioural stand-in for the
// CMAC core (fold-and-rotate accumulator, programmable completion delay).
module tb_cmac_msg_feeder;

`ifdef CMAC_FEEDER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         CLK = 1'b0;
    logic         Rst = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_load = 1'b0;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic         s_last = 1'b0;
    logic [2:0]   s_bytes = '0;
    logic [127:0] cm_KEY, cm_TextIn, cm_TextOut, tag;
    logic         cm_ld_Key, cm_ld_Block, cm_Last_Block, tag_valid, busy;
    logic [7:0]   cm_Last_Block_Len;
    logic         cm_Done = 1'b0;

    cmac_msg_feeder dut (
        .CLK(CLK), .Rst(Rst), .key_in(key_in), .key_load(key_load),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .s_bytes(s_bytes), .cm_KEY(cm_KEY), .cm_TextIn(cm_TextIn),
        .cm_ld_Key(cm_ld_Key), .cm_ld_Block(cm_ld_Block),
        .cm_Last_Block(cm_Last_Block), .cm_Last_Block_Len(cm_Last_Block_Len),
        .cm_Done(cm_Done), .cm_TextOut(cm_TextOut), .tag(tag),
        .tag_valid(tag_valid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [127:0] text;
        logic         last;
        logic [7:0]   len;
    } exp_blk_t;

    exp_blk_t     exp_blk_q[$];
    logic [127:0] exp_tag_q[$];
    logic [127:0] exp_key = KEY;
    int checks = 0;
    int passes = 0;
    int tag_cnt = 0;
    int msg_id = 0;
    int core_delay = 1;
    int core_cnt = 0;
    logic [127:0] core_acc = '0;
    logic [31:0]  wd [0:15];
    logic [7:0]   mb [0:63];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: got timeout required completion", name);
    endtask

    // Core stand-in: one job at a time, Done after core_delay cycles.
    always @(posedge CLK) begin
        cm_Done <= 1'b0;
        if (Rst) begin
            core_cnt <= 0;
            core_acc <= '0;
        end else if (cm_ld_Key) begin
            core_acc <= cm_KEY;
            core_cnt <= core_delay;
        end else if (cm_ld_Block) begin
            core_acc <= {core_acc[126:0], core_acc[127]} ^ cm_TextIn;
            core_cnt <= core_delay;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) cm_Done <= 1'b1;
        end
    end
    assign cm_TextOut = core_acc;

    // Monitor: pops the scoreboard whenever the DUT presents a load or a tag.
    initial begin
        exp_blk_t     e;
        logic [127:0] hold_text;
        logic         hold_last;
        logic [7:0]   hold_len;
        bit           hold_v;
        hold_v = 1'b0;
        hold_text = '0;
        hold_last = 1'b0;
        hold_len = '0;
        forever begin
            @(negedge CLK);
            if (Rst) begin
                hold_v = 1'b0;
            end else begin
                if (cm_ld_Key) chk("ld_key_value", cm_KEY, exp_key);
                if (cm_ld_Block) begin
                    chk("core_idle_at_load", 128'(core_cnt), 128'(0));
                    chk("key_held", cm_KEY, exp_key);
                    if (exp_blk_q.size() == 0) begin
                        checks++;
                        $display("FAIL blk_unexpected: got load %h required none", cm_TextIn);
                    end else begin
                        e = exp_blk_q.pop_front();
                        chk("blk_text", cm_TextIn, e.text);
                        chk("blk_last", 128'(cm_Last_Block), 128'(e.last));
                        if (e.last) chk("blk_len", 128'(cm_Last_Block_Len), 128'(e.len));
                    end
                    hold_text = cm_TextIn;
                    hold_last = cm_Last_Block;
                    hold_len  = cm_Last_Block_Len;
                    hold_v    = 1'b1;
                end
                if (cm_Done && hold_v) begin
                    chk("held_text", cm_TextIn, hold_text);
                    chk("held_last_len", 128'({cm_Last_Block, cm_Last_Block_Len}), 128'({hold_last, hold_len}));
                    hold_v = 1'b0;
                end
                if (tag_valid) begin
                    tag_cnt++;
                    if (exp_tag_q.size() == 0) begin
                        checks++;
                        $display("FAIL tag_unexpected: got %h required none", tag);
                    end else begin
                        chk("tag", tag, exp_tag_q.pop_front());
                    end
                    $display("tag %0d: %h", tag_cnt, tag);
                end
            end
        end
    end

    function automatic logic [127:0] mk_blk(input int base, input int cnt);
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < cnt) b[127-8*i -: 8] = mb[base+i];
            else if (PAD && i == cnt) b[127-8*i -: 8] = 8'h80;
        end
        return b;
    endfunction

    // One message: model the expected block loads and tag, then drive it.
    task automatic send_msg(input int nwords, input int lb, input int vmode,
                            input int dly, input int abort_at, input bit kl_mid);
        logic [127:0] acc;
        exp_blk_t     e;
        int  nbytes, nfull, fb, waitc, tagc0;
        bit  acc_ok, tog;
        core_delay = dly;
        for (int i = 0; i < nwords; i++) begin
            wd[i] = $urandom;
            for (int b = 0; b < 4; b++) mb[4*i+b] = wd[i][31-8*b -: 8];
        end
        nbytes = 4*(nwords-1) + lb;
        nfull  = (nwords-1) / 4;
        fb     = nbytes - 16*nfull;
        acc    = KEY;
        for (int k = 0; k < nfull; k++) begin
            e.text = mk_blk(16*k, 16);
            e.last = 1'b0;
            e.len  = 8'd128;
            exp_blk_q.push_back(e);
            acc = {acc[126:0], acc[127]} ^ e.text;
        end
        e.text = mk_blk(16*nfull, fb);
        e.last = 1'b1;
        e.len  = (fb == 16) ? 8'd128 : 8'(8*fb);
        exp_blk_q.push_back(e);
        acc = {acc[126:0], acc[127]} ^ e.text;
        exp_tag_q.push_back(acc);
        msg_id++;
        $display("msg %0d: words=%0d bytes=%0d delay=%0d abort_at=%0d", msg_id, nwords, nbytes, dly, abort_at);

        exp_key  = KEY;
        key_in   = KEY;
        key_load = 1'b1;
        @(negedge CLK);
        key_load = 1'b0;
        chk("ready_low_keywait", 128'(s_ready), 128'(0));
        chk("busy_after_key", 128'(busy), 128'(1));

        tog = 1'b1;
        for (int w = 0; w < nwords; w++) begin
            acc_ok = 1'b0;
            waitc  = 0;
            while (!acc_ok && waitc < 2000) begin
                s_data  = wd[w];
                s_last  = (w == nwords-1);
                s_bytes = s_last ? 3'(lb) : 3'($urandom_range(0, 7));
                case (vmode)
                    0:       s_valid = 1'b1;
                    1:       s_valid = tog;
                    default: s_valid = 1'($urandom_range(0, 1));
                endcase
                tog = !tog;
                acc_ok = s_valid && s_ready;
                @(negedge CLK);
                waitc++;
            end
            s_valid = 1'b0;
            if (!acc_ok) begin
                fail_now("word_accept");
                return;
            end
            if (abort_at != 0 && w+1 == abort_at) begin
                Rst = 1'b1;
                @(negedge CLK);
                exp_blk_q.delete();
                exp_tag_q.delete();
                tagc0 = tag_cnt;
                @(negedge CLK);
                Rst = 1'b0;
                repeat (30) @(negedge CLK);
                chk("abort_no_tag", 128'(tag_cnt), 128'(tagc0));
                chk("abort_idle", 128'(busy), 128'(0));
                return;
            end
            if (kl_mid && w == 5) begin
                key_in   = ~KEY;
                key_load = 1'b1;
                @(negedge CLK);
                key_load = 1'b0;
                key_in   = KEY;
            end
        end
        s_last = 1'b0;
        waitc = 0;
        while ((busy || exp_tag_q.size() != 0) && waitc < 5000) begin
            @(negedge CLK);
            waitc++;
        end
        if (waitc >= 5000) fail_now("tag_wait");
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_s_ready", 128'(s_ready), 128'(0));
        chk("rst_ld_key", 128'(cm_ld_Key), 128'(0));
        chk("rst_ld_block", 128'(cm_ld_Block), 128'(0));
        chk("rst_last_len", 128'({cm_Last_Block, cm_Last_Block_Len}), 128'(0));
        chk("rst_tag_valid_busy", 128'({tag_valid, busy}), 128'(0));
        chk("rst_tag", tag, 128'(0));
        chk("rst_text_key", cm_TextIn | cm_KEY, 128'(0));
        Rst = 1'b0;
        @(negedge CLK);

        send_msg(1, 0, 0, 3, 0, 1'b0);    // empty message
        send_msg(4, 4, 0, 3, 0, 1'b0);    // one full block
        send_msg(10, 4, 0, 4, 0, 1'b0);   // 40 bytes, final block of 8 bytes
        send_msg(16, 4, 1, 20, 0, 1'b0);  // 64 bytes, toggling valid, slow core
        send_msg(8, 4, 0, 5, 6, 1'b0);    // aborted after 6 words
        send_msg(4, 4, 0, 3, 0, 1'b0);    // clean message after abort
        send_msg(12, 2, 0, 20, 0, 1'b1);  // key_load during block wait
        send_msg(5, 0, 0, 2, 0, 1'b0);    // trailing empty word after a full block
        for (int m = 0; m < 25; m++) begin
            send_msg($urandom_range(1, 14), $urandom_range(0, 4), $urandom_range(0, 2),
                     $urandom_range(1, 6), 0, 1'b0);
        end

        chk("scoreboard_drained", 128'(exp_blk_q.size() + exp_tag_q.size()), 128'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
